split_eval_pipe: RTL and testbench
==================================

Name: split_eval_pipe

Overview:
Parametrised, pipelined successor to the fixed combinational split checkers in the BDD-solver flow. It holds a runtime-programmable table of NUM_CONS constraint slots, each an opcode over one or two packed variables plus a constant. It evaluates one candidate assignment per cycle and drives the AND of all enabled constraints over a valid/ready stream. It also returns the first failing slot and keeps running satisfied/total counters for the solver's sampling loop.

Parameters:
NUM_VARS, 50, number of packed input variables
VAR_W, 8, width of each variable slot; narrower variables are zero-extended by the packer
NUM_CONS, 16, number of constraint slots
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
cfg_we  input  1  write one constraint slot
cfg_idx  input  $clog2(NUM_CONS)  slot index
cfg_en  input  1  slot enable
cfg_op  input  3  opcode (see Behaviour)
cfg_a  input  $clog2(NUM_VARS)  operand A variable index
cfg_b  input  $clog2(NUM_VARS)  operand B variable index
cfg_k  input  VAR_W  constant operand
in_valid  input  1  assignment valid
in_ready  output  1  assignment accepted when in_valid & in_ready
in_vars  input  NUM_VARS*VAR_W  packed assignment; var i is bits [i*VAR_W +: VAR_W]
out_valid  output  1  result valid
out_ready  input  1  result consumed
out_x  output  1  AND of all enabled constraint bits
out_any_fail  output  1  at least one enabled slot evaluated 0
out_fail_idx  output  $clog2(NUM_CONS)  lowest failing slot; 0 when none fails
clr_cnt  input  1  synchronous counter clear
sat_cnt  output  CNT_W  results delivered with out_x=1
tot_cnt  output  CNT_W  results delivered

Behaviour:
- Reset: all slots disabled (en=0, op=0, a=b=k=0). out_valid=0, out_x=0, out_any_fail=0, out_fail_idx=0, counters=0. Internal stage-valid flags=0.
- Opcodes. All arithmetic is truncated to VAR_W bits; A=var[a], B=var[b]; result bit = OR-reduce of the expression.
  - 0 CONST: |k
  - 1 MUL_NZ: |(A*B)[VAR_W-1:0]
  - 2 NOT_OR_K: |(~A | k)
  - 3 LNOT_PLUS_K: |({VAR_W{0}} + (A==0) + k)
  - 4 LNOT_OR_K: |((A==0) | k)
  - 5..7 reserved: evaluate 1
  - A disabled slot evaluates 1. With no slots enabled, out_x=1.
- Pipeline, latency 2:
  - S1 registers the per-slot bit vector at acceptance, using the table contents before any same-cycle cfg write.
  - S2 registers out_x, out_any_fail and out_fail_idx (priority encoder, lowest index wins).
- Config write takes effect for assignments accepted in the following cycle or later. Data already in flight is unaffected.
- Flow control: stall = out_valid & ~out_ready; in_ready = ~stall. On stall both stages hold. Accepted assignments are never dropped or reordered.
  - Full throughput (1/cycle) when out_ready=1.
  - A bubble (in_valid=0) propagates as an invalid stage.
- Counters:
  - On each output handshake (out_valid & out_ready): tot_cnt += 1, and sat_cnt += 1 if out_x=1.
  - Both counters saturate at 2^CNT_W-1.
  - clr_cnt has priority: a same-cycle handshake is not counted, and both counters read 0 next cycle.
- Reset asserted mid-stream flushes both stages and the table immediately; no partial result is emitted after release.

Optional Feature:
SPLIT_EVAL_FAIL_MASK_EN
- Defined: adds output out_fail_mask[NUM_CONS-1:0], registered in S2 alongside out_x. Bit i=1 iff slot i is enabled and evaluated 0. Reset 0.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package split_eval_pkg: the opcode enum (OP_CONST..OP_LNOT_OR_K), the slot config struct {en, op, a, b, k}, and the index-width helper function.
- Sub-module split_cons_unit: purely combinational single-slot evaluator (config struct + in_vars → 1 bit), instantiated NUM_CONS times.
- Top level owns the table, pipeline registers, priority encoder and counters.

Test Plan:
- Reset, no config, one assignment with all vars=0 → out_valid exactly 2 cycles after accept; out_x=1, out_any_fail=0, out_fail_idx=0.
- Slot 0 MUL_NZ a=48 b=0. var48=0x10, var0=0x10 → product 0x100 truncates to 0x00 → out_x=0, out_fail_idx=0. var0=0x03 → out_x=1.
- Slot 3 NOT_OR_K a=48. k=0xA6, var48=0xFF → pass. k=0x00, var48=0xFF → out_x=0, out_fail_idx=3. Slots 3 and 7 both failing → out_fail_idx=3.
- Slot 2 LNOT_PLUS_K a=5 k=0xFF. var5=0 → 0x100 truncates to 0 → fail. var5=5 → 0xFF → pass. Slot rewritten to k=0x01 in the same cycle as an accept → that assignment uses k=0xFF; the next assignment uses k=0x01.
- out_ready=0 for 6 cycles while 3 assignments are offered → in_ready drops once out_valid is high. Results emerge in order after release; tot_cnt=3.
- CNT_W=4, 20 handshakes with out_x=1 → tot_cnt=sat_cnt=15. clr_cnt asserted together with a handshake → both counters 0 next cycle.

Source files
------------

// File: rtl/split_eval_pkg.sv
// Shared types for the split-constraint evaluator: opcode enum, slot config struct
// and the index-width helper used to size slot/variable index fields.
package split_eval_pkg;

  localparam int IDX_MAX_W = 8;
  localparam int K_MAX_W   = 32;

  typedef enum logic [2:0] {
    OP_CONST       = 3'd0,
    OP_MUL_NZ      = 3'd1,
    OP_NOT_OR_K    = 3'd2,
    OP_LNOT_PLUS_K = 3'd3,
    OP_LNOT_OR_K   = 3'd4,
    OP_RSVD5       = 3'd5,
    OP_RSVD6       = 3'd6,
    OP_RSVD7       = 3'd7
  } op_e;

  // a/b/k are stored zero-extended to fixed maxima so one struct serves every instance
  typedef struct packed {
    logic                 en;
    op_e                  op;
    logic [IDX_MAX_W-1:0] a;
    logic [IDX_MAX_W-1:0] b;
    logic [K_MAX_W-1:0]   k;
  } slot_cfg_t;

  function automatic int idx_w(input int n);
    if (n > 1) return $clog2(n);
    else return 1;
  endfunction

endpackage

// File: rtl/split_eval_pipe_if.sv
// Config, assignment and result stream bundle for split_eval_pipe.
// Carries out_fail_mask only when SPLIT_EVAL_FAIL_MASK_EN is defined.
interface split_eval_pipe_if
  import split_eval_pkg::*;
#(
  parameter int NUM_VARS = 50,
  parameter int VAR_W    = 8,
  parameter int NUM_CONS = 16
);
  localparam int CI_W = idx_w(NUM_CONS);
  localparam int VI_W = idx_w(NUM_VARS);

  logic                      cfg_we;
  logic [CI_W-1:0]           cfg_idx;
  logic                      cfg_en;
  logic [2:0]                cfg_op;
  logic [VI_W-1:0]           cfg_a;
  logic [VI_W-1:0]           cfg_b;
  logic [VAR_W-1:0]          cfg_k;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_VARS*VAR_W-1:0] in_vars;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_x;
  logic                      out_any_fail;
  logic [CI_W-1:0]           out_fail_idx;
`ifdef SPLIT_EVAL_FAIL_MASK_EN
  logic [NUM_CONS-1:0]       out_fail_mask;
`endif

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_op, cfg_a, cfg_b, cfg_k,
    output in_valid, in_vars, out_ready,
    input  in_ready, out_valid, out_x, out_any_fail, out_fail_idx
`ifdef SPLIT_EVAL_FAIL_MASK_EN
    , input out_fail_mask
`endif
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_op, cfg_a, cfg_b, cfg_k,
    input  in_valid, in_vars, out_ready,
    output in_ready, out_valid, out_x, out_any_fail, out_fail_idx
`ifdef SPLIT_EVAL_FAIL_MASK_EN
    , output out_fail_mask
`endif
  );

endinterface

// File: rtl/split_cons_unit.sv
// Combinational evaluator for one constraint slot: config + packed assignment -> pass bit.
module split_cons_unit
  import split_eval_pkg::*;
#(
  parameter int NUM_VARS = 50,
  parameter int VAR_W    = 8
) (
  input  slot_cfg_t                 cfg,
  input  logic [NUM_VARS*VAR_W-1:0] vars,
  output logic                      pass
);
  localparam int VI_W = idx_w(NUM_VARS);

  logic [VAR_W-1:0] var_s [NUM_VARS];
  logic [VAR_W-1:0] a_s, b_s, k_s, prod_s, a_zero_s;
  logic             res_s;

  for (genvar i = 0; i < NUM_VARS; i++) begin : g_unpack
    assign var_s[i] = vars[i*VAR_W +: VAR_W];
  end

  // Operand fetch and opcode evaluation; all arithmetic wraps at VAR_W bits
  always_comb begin
    if (int'(cfg.a) < NUM_VARS) a_s = var_s[cfg.a[VI_W-1:0]];
    else a_s = '0;
    if (int'(cfg.b) < NUM_VARS) b_s = var_s[cfg.b[VI_W-1:0]];
    else b_s = '0;
    k_s      = cfg.k[VAR_W-1:0];
    prod_s   = a_s * b_s;
    a_zero_s = {{(VAR_W-1){1'b0}}, (a_s == '0)};
    case (cfg.op)
      OP_CONST:       res_s = |cfg.k;
      OP_MUL_NZ:      res_s = |prod_s;
      OP_NOT_OR_K:    res_s = |(~a_s | k_s);
      OP_LNOT_PLUS_K: res_s = |(a_zero_s + k_s);
      OP_LNOT_OR_K:   res_s = |(a_zero_s | k_s);
      default:        res_s = 1'b1;
    endcase
    if (cfg.en) pass = res_s;
    else pass = 1'b1;
  end

endmodule

// File: rtl/split_eval_pipe.sv
// Two-stage pipelined constraint evaluator with programmable slot table and result counters.
// Optional out_fail_mask output is built when SPLIT_EVAL_FAIL_MASK_EN is defined.
module split_eval_pipe
  import split_eval_pkg::*;
#(
  parameter int NUM_VARS = 50,
  parameter int VAR_W    = 8,
  parameter int NUM_CONS = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  split_eval_pipe_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [CNT_W-1:0] tot_cnt
);
  localparam int CI_W = idx_w(NUM_CONS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_cfg_t           table_r [NUM_CONS];
  slot_cfg_t           wr_cfg_s;
  logic [NUM_CONS-1:0] eval_s, s1_bits_r;
  logic                s1_valid_r, out_valid_r, out_x_r, out_any_fail_r;
  logic [CI_W-1:0]     out_fail_idx_r, fail_idx_s;
  logic [CNT_W-1:0]    sat_cnt_r, tot_cnt_r;
  logic                stall_s, hs_s;

  assign stall_s = out_valid_r & ~bus.out_ready;
  assign hs_s    = out_valid_r & bus.out_ready;

  // Widen the incoming slot fields into the stored struct layout
  always_comb begin
    wr_cfg_s    = '0;
    wr_cfg_s.en = bus.cfg_en;
    wr_cfg_s.op = op_e'(bus.cfg_op);
    wr_cfg_s.a  = IDX_MAX_W'(bus.cfg_a);
    wr_cfg_s.b  = IDX_MAX_W'(bus.cfg_b);
    wr_cfg_s.k  = K_MAX_W'(bus.cfg_k);
  end

  // Slot table; a write lands at the edge, so an assignment accepted the same cycle sees old contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONS; i++) table_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CONS; i++) begin
        if (bus.cfg_we && (bus.cfg_idx == CI_W'(i))) table_r[i] <= wr_cfg_s;
      end
    end
  end

  for (genvar i = 0; i < NUM_CONS; i++) begin : g_cons
    split_cons_unit #(.NUM_VARS(NUM_VARS), .VAR_W(VAR_W)) u_cons (
      .cfg  (table_r[i]),
      .vars (bus.in_vars),
      .pass (eval_s[i])
    );
  end

  // Lowest failing slot wins; zero when every slot passes
  always_comb begin
    fail_idx_s = '0;
    for (int i = NUM_CONS - 1; i >= 0; i--) begin
      if (!s1_bits_r[i]) fail_idx_s = CI_W'(i);
      else fail_idx_s = fail_idx_s;
    end
  end

  // S1 captures per-slot bits, S2 the reduced result; both freeze while the output stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r     <= 1'b0;
      s1_bits_r      <= '0;
      out_valid_r    <= 1'b0;
      out_x_r        <= 1'b0;
      out_any_fail_r <= 1'b0;
      out_fail_idx_r <= '0;
    end else if (!stall_s) begin
      s1_valid_r  <= bus.in_valid;
      out_valid_r <= s1_valid_r;
      if (bus.in_valid) s1_bits_r <= eval_s;
      if (s1_valid_r) begin
        out_x_r        <= &s1_bits_r;
        out_any_fail_r <= ~&s1_bits_r;
        out_fail_idx_r <= fail_idx_s;
      end
    end
  end

`ifdef SPLIT_EVAL_FAIL_MASK_EN
  logic [NUM_CONS-1:0] fail_mask_r;

  // Disabled slots always pass, so inverting the bits yields the enabled-and-failing mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fail_mask_r <= '0;
    else if (!stall_s && s1_valid_r) fail_mask_r <= ~s1_bits_r;
  end

  assign bus.out_fail_mask = fail_mask_r;
`else
  // mask output not built
`endif

  // Saturating statistics; a clear discards any same-cycle handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_r <= '0;
      tot_cnt_r <= '0;
    end else if (clr_cnt) begin
      sat_cnt_r <= '0;
      tot_cnt_r <= '0;
    end else if (hs_s) begin
      if (tot_cnt_r != CNT_MAX) tot_cnt_r <= tot_cnt_r + 1'b1;
      if (out_x_r && (sat_cnt_r != CNT_MAX)) sat_cnt_r <= sat_cnt_r + 1'b1;
    end
  end

  assign bus.in_ready     = ~stall_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_x        = out_x_r;
  assign bus.out_any_fail = out_any_fail_r;
  assign bus.out_fail_idx = out_fail_idx_r;
  assign sat_cnt          = sat_cnt_r;
  assign tot_cnt          = tot_cnt_r;

endmodule

// File: tb/tb_split_eval_pipe.sv
// Directed self-checking bench for split_eval_pipe (counters built 4 bits wide).
module tb_split_eval_pipe;
  import split_eval_pkg::*;

  localparam int NV = 50;
  localparam int VW = 8;
  localparam int NC = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] sat_cnt, tot_cnt;

  split_eval_pipe_if #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC)) bus ();

  split_eval_pipe #(.NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .clr_cnt (clr_cnt),
    .sat_cnt (sat_cnt),
    .tot_cnt (tot_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [NV*VW-1:0] v;
  logic       rx, rany;
  logic [3:0] ridx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic setv(input int i, input logic [7:0] val);
    v[i*VW +: VW] = val;
  endtask

  task automatic set_cfg(input int idx, input logic en, input logic [2:0] op,
                         input int a, input int b, input logic [7:0] k);
    bus.cfg_idx = 4'(idx);
    bus.cfg_en  = en;
    bus.cfg_op  = op;
    bus.cfg_a   = 6'(a);
    bus.cfg_b   = 6'(b);
    bus.cfg_k   = k;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [2:0] op,
                           input int a, input int b, input logic [7:0] k);
    @(negedge clk);
    set_cfg(idx, en, op, a, b, k);
    bus.cfg_we = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // Offer one assignment on an empty pipe and return the result; checks the 2-cycle latency
  task automatic eval_vec(input logic [NV*VW-1:0] vec, input bit with_cfg,
                          output logic x, output logic any, output logic [3:0] idx);
    int lat;
    @(negedge clk);
    bus.in_vars  = vec;
    bus.in_valid = 1'b1;
    if (with_cfg) bus.cfg_we = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 8);
    check("latency", 32'(lat), 32'd2);
    x   = bus.out_x;
    any = bus.out_any_fail;
    idx = bus.out_fail_idx;
  endtask

  initial begin
    logic [NV*VW-1:0] sv [3];
    logic [4:0]       res [3];
    int k, nres;
    bit acc, seen;

    bus.cfg_we = 1'b0;
    set_cfg(0, 1'b0, 3'd0, 0, 0, 8'h00);
    bus.in_valid  = 1'b0;
    bus.in_vars   = '0;
    bus.out_ready = 1'b1;
    v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_x", 32'(bus.out_x), 32'd0);
    check("rst_any_fail", 32'(bus.out_any_fail), 32'd0);
    check("rst_fail_idx", 32'(bus.out_fail_idx), 32'd0);
    check("rst_tot", 32'(tot_cnt), 32'd0);
    check("rst_sat", 32'(sat_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // No slots enabled: everything passes
    v = '0;
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("empty_x", 32'(rx), 32'd1);
    check("empty_any", 32'(rany), 32'd0);
    check("empty_idx", 32'(ridx), 32'd0);
    @(negedge clk);
    check("first_tot", 32'(tot_cnt), 32'd1);
    check("first_sat", 32'(sat_cnt), 32'd1);

    // MUL_NZ: 0x10*0x10 wraps to 0
    cfg_write(0, 1'b1, OP_MUL_NZ, 48, 0, 8'h00);
    v = '0; setv(48, 8'h10); setv(0, 8'h10);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("mul_wrap_x", 32'(rx), 32'd0);
    check("mul_wrap_any", 32'(rany), 32'd1);
    check("mul_wrap_idx", 32'(ridx), 32'd0);
    setv(0, 8'h03);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("mul_nz_x", 32'(rx), 32'd1);
    cfg_write(0, 1'b0, OP_CONST, 0, 0, 8'h00);

    // NOT_OR_K and priority encoding
    cfg_write(3, 1'b1, OP_NOT_OR_K, 48, 0, 8'hA6);
    v = '0; setv(48, 8'hFF);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("notor_pass_x", 32'(rx), 32'd1);
    cfg_write(3, 1'b1, OP_NOT_OR_K, 48, 0, 8'h00);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("notor_fail_x", 32'(rx), 32'd0);
    check("notor_fail_idx", 32'(ridx), 32'd3);
    cfg_write(7, 1'b1, OP_NOT_OR_K, 48, 0, 8'h00);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("prio_3_7_idx", 32'(ridx), 32'd3);
    cfg_write(3, 1'b0, OP_CONST, 0, 0, 8'h00);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("prio_7_idx", 32'(ridx), 32'd7);
    cfg_write(7, 1'b0, OP_CONST, 0, 0, 8'h00);

    // LNOT_PLUS_K: 1+0xFF wraps to 0; same-cycle rewrite applies to the next assignment only
    cfg_write(2, 1'b1, OP_LNOT_PLUS_K, 5, 0, 8'hFF);
    v = '0;
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("lpk_wrap_x", 32'(rx), 32'd0);
    check("lpk_wrap_idx", 32'(ridx), 32'd2);
    setv(5, 8'h05);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("lpk_pass_x", 32'(rx), 32'd1);
    v = '0;
    set_cfg(2, 1'b1, OP_LNOT_PLUS_K, 5, 0, 8'h01);
    eval_vec(v, 1'b1, rx, rany, ridx);
    check("cfg_same_cycle_x", 32'(rx), 32'd0);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("cfg_next_cycle_x", 32'(rx), 32'd1);
    cfg_write(2, 1'b0, OP_CONST, 0, 0, 8'h00);

    // CONST with k=0 fails, reserved opcode passes
    cfg_write(9, 1'b1, OP_CONST, 0, 0, 8'h00);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("const0_idx", 32'(ridx), 32'd9);
    check("const0_x", 32'(rx), 32'd0);
    cfg_write(9, 1'b1, 3'd5, 0, 0, 8'h00);
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("rsvd_x", 32'(rx), 32'd1);
    cfg_write(9, 1'b0, OP_CONST, 0, 0, 8'h00);

    // Backpressure: 6 stalled cycles, 3 offers, in-order drain
    cfg_write(4, 1'b1, OP_LNOT_OR_K, 1, 0, 8'h00);
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    check("clr_tot", 32'(tot_cnt), 32'd0);
    sv[0] = '0; sv[1] = '0; sv[1][1*VW +: VW] = 8'h07; sv[2] = '0;
    k = 0; nres = 0; acc = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 30 && nres < 3; c++) begin
      @(negedge clk);
      if (acc) k++;
      if (c == 6) bus.out_ready = 1'b1;
      if (c == 5) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_accepted", 32'(k), 32'd2);
        check("stall_tot", 32'(tot_cnt), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        res[nres] = {bus.out_x, bus.out_fail_idx};
        nres++;
      end
      if (k < 3) begin
        bus.in_valid = 1'b1;
        bus.in_vars  = sv[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
    end
    bus.in_valid = 1'b0;
    check("drain_count", 32'(nres), 32'd3);
    check("drain_res0", 32'(res[0]), 32'h10);
    check("drain_res1", 32'(res[1]), 32'h04);
    check("drain_res2", 32'(res[2]), 32'h10);
    @(negedge clk);
    check("drain_tot", 32'(tot_cnt), 32'd3);
    check("drain_sat", 32'(sat_cnt), 32'd2);
    cfg_write(4, 1'b0, OP_CONST, 0, 0, 8'h00);

    // Saturation after 20 passing handshakes
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    bus.in_vars = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
    end
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_tot", 32'(tot_cnt), 32'd15);
    check("sat_sat", 32'(sat_cnt), 32'd15);

    // Clear wins over a same-cycle handshake
    @(negedge clk); bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("clr_hs_valid", 32'(seen), 32'd1);
    clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    check("clr_hs_tot", 32'(tot_cnt), 32'd0);
    check("clr_hs_sat", 32'(sat_cnt), 32'd0);

    // Reset mid-stream flushes the pipe and the table
    cfg_write(9, 1'b1, OP_CONST, 0, 0, 8'h00);
    @(negedge clk); bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_flush_valid", 32'(seen), 32'd0);
    v = '0;
    eval_vec(v, 1'b0, rx, rany, ridx);
    check("rst_table_x", 32'(rx), 32'd1);
    @(negedge clk);
    check("rst_post_tot", 32'(tot_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
